// File: rtl/afifo72_wr_arbiter_if.sv
// afifo72_wr_arbiter_if: requester handshakes and FIFO write port of the write arbiter
interface afifo72_wr_arbiter_if #(parameter int DW = 72);
  logic [DW-1:0] req0_din, req1_din, fifo_din;
  logic req0_valid, req0_ready, req1_valid, req1_ready, fifo_wr_en, fifo_full;
  modport master(output req0_din, req0_valid, req1_din, req1_valid, fifo_full,
                 input req0_ready, req1_ready, fifo_din, fifo_wr_en);
  modport slave(input req0_din, req0_valid, req1_din, req1_valid, fifo_full,
                output req0_ready, req1_ready, fifo_din, fifo_wr_en);
endinterface

// File: rtl/afifo72_wr_arbiter.sv
// afifo72_wr_arbiter: frame-granular round-robin share of the async FIFO write port with port stamping
module afifo72_wr_arbiter #(
  parameter int DATA_WIDTH = 72,
  parameter int MAX_BEATS  = 512,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  afifo72_wr_arbiter_if.slave  bus,
  input  logic                 i_clr_stat,
  output logic [1:0]           o_grant,
  output logic [CNT_WIDTH-1:0] o_frm_cnt0,
  output logic [CNT_WIDTH-1:0] o_frm_cnt1,
  output logic                 o_trunc_err
);
  localparam int DW = DATA_WIDTH;
  localparam int BW = $clog2(MAX_BEATS + 1);
  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;
  state_t          r_state, w_next;
  logic            r_last, r_out_valid;
  logic [BW-1:0]   r_beats, w_beats_nx;
  logic [DW-1:0]   r_out_din;
  logic [DW-3:0]   w_pay;
  logic            w_port, w_ready, w_valid, w_eof_in, w_max, w_eof, w_acc, w_end, w_wr;
  assign w_port     = r_state == BUSY1;
  assign w_ready    = !r_out_valid | !bus.fifo_full;
  assign w_valid    = w_port ? bus.req1_valid : bus.req0_valid;
  assign w_pay      = w_port ? bus.req1_din[DW-3:0] : bus.req0_din[DW-3:0];
  assign w_eof_in   = w_port ? bus.req1_din[DW-1] : bus.req0_din[DW-1];
  assign w_acc      = (r_state != IDLE) & w_valid & w_ready;
  assign w_beats_nx = r_beats + 1'b1;
  assign w_max      = w_beats_nx == BW'(MAX_BEATS);
  assign w_eof      = w_eof_in | w_max;
  assign w_end      = w_acc & w_eof;
  assign w_wr       = r_out_valid & !bus.fifo_full;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_next != IDLE) r_last <= w_next == BUSY1;
    end
  // a tie goes to the port that did not own the previous frame
  always_comb
    w_next = (r_state == IDLE)
      ? ((bus.req0_valid & (!bus.req1_valid | r_last)) ? BUSY0 : bus.req1_valid ? BUSY1 : IDLE)
      : (w_end ? IDLE : r_state);
  always_comb begin
    o_grant        = {r_state == BUSY1, r_state == BUSY0};
    bus.req0_ready = (r_state == BUSY0) & w_ready;
    bus.req1_ready = (r_state == BUSY1) & w_ready;
    bus.fifo_wr_en = w_wr;
    bus.fifo_din   = r_out_din;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_beats     <= '0;
      r_out_valid <= 1'b0;
      r_out_din   <= '0;
    end else if (w_acc) begin
      r_beats     <= w_eof ? '0 : w_beats_nx;
      r_out_valid <= 1'b1;
      r_out_din   <= {w_eof, w_port, w_pay};
    end else if (w_wr) begin
      r_out_valid <= 1'b0;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      o_frm_cnt0  <= '0;
      o_frm_cnt1  <= '0;
      o_trunc_err <= 1'b0;
    end else if (i_clr_stat) begin
      o_frm_cnt0  <= '0;
      o_frm_cnt1  <= '0;
      o_trunc_err <= 1'b0;
    end else begin
      if (w_end & !w_port) o_frm_cnt0 <= o_frm_cnt0 + 1'b1;
      if (w_end & w_port) o_frm_cnt1 <= o_frm_cnt1 + 1'b1;
      if (w_acc & w_max & !w_eof_in) o_trunc_err <= 1'b1;
    end
endmodule
